spi_master_core: RTL and testbench

SPI_MASTER_CORE -- requirements
Module: spi_master_core

---
 rtl/spi_pkg.sv | 14 +
 rtl/spi_clk_div.sv | 51 +++++
 rtl/spi_master_core.sv | 138 +++++++++++++
 tb/tb_spi_master_core.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI master core and its clock divider.
package spi_pkg;

    localparam int unsigned DEFAULT_DATA_WIDTH = 8;
    localparam int unsigned DEFAULT_CLK_DIV    = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        LOAD  = 2'd1,
        SHIFT = 2'd2,
        DONE  = 2'd3
    } spi_state_e;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator and sclk register with rise/fall strobes.
module spi_clk_div
    import spi_pkg::*;
#(
    parameter int unsigned CLK_DIV = DEFAULT_CLK_DIV
) (
    input  logic clk,
    input  logic rst_n,
    input  logic cnt_en_i,
    input  logic cnt_clr_i,
    input  logic sclk_en_i,
    output logic tick_o,
    output logic sclk_o,
    output logic rise_o,
    output logic fall_o
);

    localparam int unsigned CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;

    logic [CW-1:0] cnt_q, cnt_d;
    logic          sclk_q, sclk_d;

    assign tick_o = cnt_en_i && (cnt_q == CW'(CLK_DIV - 1));
    assign sclk_o = sclk_q;
    assign rise_o = sclk_en_i && tick_o && !sclk_q;
    assign fall_o = sclk_en_i && tick_o && sclk_q;

    always_comb begin
        cnt_d  = cnt_q;
        sclk_d = sclk_q;
        if (cnt_clr_i) begin
            cnt_d = '0;
        end else if (cnt_en_i) begin
            cnt_d = tick_o ? '0 : cnt_q + CW'(1);
        end
        if (sclk_en_i && tick_o) begin
            sclk_d = ~sclk_q;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q  <= '0;
            sclk_q <= 1'b0;
        end else begin
            cnt_q  <= cnt_d;
            sclk_q <= sclk_d;
        end
    end

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master between a TX and an RX FIFO; one word per cs_n frame.
// Define SPI_MASTER_BURST_EN to chain queued words inside a single frame.
module spi_master_core
    import spi_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int unsigned CLK_DIV    = DEFAULT_CLK_DIV
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [DATA_WIDTH-1:0] tx_data,
    input  logic                  tx_empty,
    output logic                  tx_rd_en,
    output logic [DATA_WIDTH-1:0] rx_data,
    output logic                  rx_wr_en,
    input  logic                  rx_full,
    output logic                  rx_drop,
    output logic                  sclk,
    output logic                  mosi,
    output logic                  cs_n,
    input  logic                  miso,
    output logic                  busy
);

    localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;

    spi_state_e            state_q, state_d;
    logic [DATA_WIDTH-1:0] tx_q, tx_d;
    logic [DATA_WIDTH-1:0] rx_sh_q, rx_sh_d;
    logic [DATA_WIDTH-1:0] rx_data_q, rx_data_d;
    logic [BW-1:0]         bit_q, bit_d;
    logic                  gap_q, gap_d;
    logic                  tick, rise, fall, cnt_clr;

    spi_clk_div #(.CLK_DIV(CLK_DIV)) u_clk_div (
        .clk       (clk),
        .rst_n     (rst_n),
        .cnt_en_i  (state_q != DONE),
        .cnt_clr_i (cnt_clr),
        .sclk_en_i (state_q == SHIFT),
        .tick_o    (tick),
        .sclk_o    (sclk),
        .rise_o    (rise),
        .fall_o    (fall)
    );

    assign busy    = (state_q != IDLE);
    assign cs_n    = (state_q == IDLE);
    assign mosi    = (state_q != IDLE) && tx_q[DATA_WIDTH-1];
    // The pushed word is only visible during DONE; otherwise the last pushed word is held.
    assign rx_data = (state_q == DONE) ? rx_sh_q : rx_data_q;

    always_comb begin
        state_d   = state_q;
        tx_d      = tx_q;
        rx_sh_d   = rx_sh_q;
        rx_data_d = rx_data_q;
        bit_d     = bit_q;
        gap_d     = 1'b0;
        cnt_clr   = 1'b0;
        tx_rd_en  = 1'b0;
        rx_wr_en  = 1'b0;
        rx_drop   = 1'b0;
        unique case (state_q)
            IDLE: begin
                // gap_q remembers that cs_n has been high for a full half-period.
                gap_d = gap_q || tick;
                if (enable && !tx_empty && (gap_q || tick)) begin
                    tx_rd_en = 1'b1;
                    tx_d     = tx_data;
                    cnt_clr  = 1'b1;
                    gap_d    = 1'b0;
                    state_d  = LOAD;
                end
            end
            LOAD: begin
                if (tick) begin
                    state_d = SHIFT;
                end
            end
            SHIFT: begin
                if (rise) begin
                    rx_sh_d = {rx_sh_q[DATA_WIDTH-2:0], miso};
                end
                if (fall) begin
                    tx_d = {tx_q[DATA_WIDTH-2:0], 1'b0};
                    if (bit_q == BW'(DATA_WIDTH - 1)) begin
                        bit_d   = '0;
                        state_d = DONE;
                    end else begin
                        bit_d = bit_q + BW'(1);
                    end
                end
            end
            DONE: begin
                cnt_clr = 1'b1;
                if (!rx_full) begin
                    rx_wr_en  = 1'b1;
                    rx_data_d = rx_sh_q;
                end else begin
                    rx_drop = 1'b1;
                end
`ifdef SPI_MASTER_BURST_EN
                if (enable && !tx_empty) begin
                    tx_rd_en = 1'b1;
                    tx_d     = tx_data;
                    state_d  = SHIFT;
                end else begin
                    state_d = IDLE;
                end
`else
                state_d = IDLE;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            tx_q      <= '0;
            rx_sh_q   <= '0;
            rx_data_q <= '0;
            bit_q     <= '0;
            gap_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            tx_q      <= tx_d;
            rx_sh_q   <= rx_sh_d;
            rx_data_q <= rx_data_d;
            bit_q     <= bit_d;
            gap_q     <= gap_d;
        end
    end

endmodule

// File: tb/tb_spi_master_core.sv
// Table-driven bench for spi_master_core (DATA_WIDTH=8, CLK_DIV=2), with a modelled TX FIFO queue.
module tb_spi_master_core;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       enable;
    logic [7:0] tx_data;
    logic       tx_empty;
    logic       tx_rd_en;
    logic [7:0] rx_data;
    logic       rx_wr_en;
    logic       rx_full;
    logic       rx_drop;
    logic       sclk;
    logic       mosi;
    logic       cs_n;
    logic       miso;
    logic       busy;
    logic       loop_m;
    logic       slave_miso;

    int unsigned n_total = 0;
    int unsigned n_pass  = 0;

    logic [7:0] txq[$];

    assign miso = loop_m ? mosi : slave_miso;

    always #5 clk = ~clk;

    spi_master_core #(.DATA_WIDTH(8), .CLK_DIV(2)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .enable   (enable),
        .tx_data  (tx_data),
        .tx_empty (tx_empty),
        .tx_rd_en (tx_rd_en),
        .rx_data  (rx_data),
        .rx_wr_en (rx_wr_en),
        .rx_full  (rx_full),
        .rx_drop  (rx_drop),
        .sclk     (sclk),
        .mosi     (mosi),
        .cs_n     (cs_n),
        .miso     (miso),
        .busy     (busy)
    );

    typedef struct {
        logic [7:0]  w0;
        logic [7:0]  w1;
        int unsigned nw;
        bit          loopb;
        logic [7:0]  pat;
        bit          full;
        int unsigned drop_at;
        int unsigned rst_at;
        int unsigned cycles;
        int unsigned e_pops;
        int unsigned e_push;
        int unsigned e_drop;
        int unsigned e_rises;
        int unsigned e_segs;
        int unsigned e_cslow;
        bit          chk_gap;
        int unsigned e_gap;
        logic [7:0]  e_mosi;
        logic [7:0]  e_rx_evt;
        logic [7:0]  e_rx_end;
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, want 0x%0h", name, act, exp);
    endtask

    task automatic fifo_refresh();
        tx_empty = (txq.size() == 0);
        if (txq.size() != 0) tx_data = txq[0];
        else tx_data = 8'h00;
    endtask

    function automatic vec_t mk(
        input logic [7:0] w0, input logic [7:0] w1, input int unsigned nw,
        input bit loopb, input logic [7:0] pat, input bit full,
        input int unsigned drop_at, input int unsigned rst_at, input int unsigned cycles,
        input int unsigned e_pops, input int unsigned e_push, input int unsigned e_drop,
        input int unsigned e_rises, input int unsigned e_segs, input int unsigned e_cslow,
        input bit chk_gap, input int unsigned e_gap,
        input logic [7:0] e_mosi, input logic [7:0] e_rx_evt, input logic [7:0] e_rx_end);
        vec_t v;
        v.w0 = w0; v.w1 = w1; v.nw = nw; v.loopb = loopb; v.pat = pat; v.full = full;
        v.drop_at = drop_at; v.rst_at = rst_at; v.cycles = cycles;
        v.e_pops = e_pops; v.e_push = e_push; v.e_drop = e_drop; v.e_rises = e_rises;
        v.e_segs = e_segs; v.e_cslow = e_cslow; v.chk_gap = chk_gap; v.e_gap = e_gap;
        v.e_mosi = e_mosi; v.e_rx_evt = e_rx_evt; v.e_rx_end = e_rx_end;
        return v;
    endfunction

    task automatic run_vec(input vec_t v, input int unsigned idx);
        int unsigned pops = 0, pushes = 0, drops = 0, rises = 0, segs = 0;
        int unsigned cslow = 0, high_run = 0, gap = 0, viol = 0, rst_hold = 0;
        bit          in_low = 0, gap_set = 0, pop_pend = 0, rst_done = 0, prev_sclk = 0;
        logic [7:0]  mosi_sh = 8'h00;
        logic [7:0]  rx_evt = 8'h00;
        int          k;
        txq.delete();
        txq.push_back(v.w0);
        if (v.nw > 1) txq.push_back(v.w1);
        fifo_refresh();
        enable     = 1'b1;
        rx_full    = v.full;
        loop_m     = v.loopb;
        slave_miso = v.pat[7];
        prev_sclk  = sclk;
        for (int unsigned cyc = 0; cyc < v.cycles; cyc++) begin
            @(negedge clk);
            if (tx_rd_en && tx_empty) viol++;
            if (tx_rd_en) begin pops++; pop_pend = 1; end
            if (rx_wr_en) begin pushes++; rx_evt = rx_data; end
            if (rx_drop) begin drops++; rx_evt = rx_data; end
            if (!cs_n) begin
                if (!in_low) begin
                    if (segs > 0 && !gap_set) begin gap = high_run; gap_set = 1; end
                    segs++;
                    in_low = 1;
                end
                if (segs == 1) cslow++;
            end else begin
                if (in_low) begin in_low = 0; high_run = 0; end
                high_run++;
            end
            if (sclk && !prev_sclk) begin
                rises++;
                mosi_sh = {mosi_sh[6:0], mosi};
            end
            prev_sclk = sclk;
            if (v.drop_at != 0 && rises == v.drop_at) enable = 1'b0;
            if (v.rst_at != 0 && rises == v.rst_at && !rst_done) begin
                rst_n    = 1'b0;
                rst_done = 1;
                rst_hold = 2;
                #1;
                check($sformatf("v%0d_rst_cs_n", idx), cs_n, 1);
                check($sformatf("v%0d_rst_sclk", idx), sclk, 0);
                check($sformatf("v%0d_rst_busy", idx), busy, 0);
                prev_sclk = sclk;
            end
            k = 7 - int'(rises);
            if (k >= 0) slave_miso = v.pat[k];
            @(posedge clk);
            #1;
            if (pop_pend) begin
                void'(txq.pop_front());
                fifo_refresh();
                pop_pend = 0;
            end
            if (rst_hold > 0) begin
                rst_hold--;
                if (rst_hold == 0) rst_n = 1'b1;
            end
        end
        check($sformatf("v%0d_pops", idx), pops, v.e_pops);
        check($sformatf("v%0d_pushes", idx), pushes, v.e_push);
        check($sformatf("v%0d_drops", idx), drops, v.e_drop);
        check($sformatf("v%0d_sclk_pulses", idx), rises, v.e_rises);
        check($sformatf("v%0d_cs_frames", idx), segs, v.e_segs);
        check($sformatf("v%0d_cs_low_len", idx), cslow, v.e_cslow);
        if (v.chk_gap) check($sformatf("v%0d_cs_gap", idx), gap, v.e_gap);
        check($sformatf("v%0d_mosi_bits", idx), mosi_sh, v.e_mosi);
        check($sformatf("v%0d_rx_word", idx), rx_evt, v.e_rx_evt);
        check($sformatf("v%0d_rx_hold", idx), rx_data, v.e_rx_end);
        check($sformatf("v%0d_busy_end", idx), busy, 0);
        check($sformatf("v%0d_pop_while_empty", idx), viol, 0);
    endtask

    vec_t vecs[6];

    initial begin
        rst_n      = 1'b0;
        enable     = 1'b1;
        tx_empty   = 1'b0;
        tx_data    = 8'hA5;
        rx_full    = 1'b0;
        loop_m     = 1'b1;
        slave_miso = 1'b0;
        repeat (3) @(negedge clk);
        check("reset_sclk", sclk, 0);
        check("reset_cs_n", cs_n, 1);
        check("reset_mosi", mosi, 0);
        check("reset_tx_rd_en", tx_rd_en, 0);
        check("reset_rx_wr_en", rx_wr_en, 0);
        check("reset_rx_drop", rx_drop, 0);
        check("reset_busy", busy, 0);
        check("reset_rx_data", rx_data, 0);
        enable = 1'b0;
        txq.delete();
        fifo_refresh();
        @(negedge clk);
        rst_n = 1'b1;

        //            w0     w1     nw lp pat   full drop rst cyc  pops push drop rise segs cslow gchk gap mosi   rxevt  rxend
        vecs[0] = mk(8'hA5, 8'h00, 1, 1, 8'h00, 0,   0,   0,  70,  1,   1,   0,   8,   1,   35,   1,   0,  8'hA5, 8'hA5, 8'hA5);
        vecs[1] = mk(8'hFF, 8'h00, 1, 0, 8'h3C, 0,   0,   0,  70,  1,   1,   0,   8,   1,   35,   1,   0,  8'hFF, 8'h3C, 8'h3C);
        vecs[2] = mk(8'h5A, 8'h00, 1, 1, 8'h00, 1,   0,   0,  70,  1,   0,   1,   8,   1,   35,   1,   0,  8'h5A, 8'h5A, 8'h3C);
`ifdef SPI_MASTER_BURST_EN
        vecs[3] = mk(8'h11, 8'h22, 2, 1, 8'h00, 0,   0,   0, 110,  2,   2,   0,  16,   1,   68,   1,   0,  8'h22, 8'h22, 8'h22);
`else
        vecs[3] = mk(8'h11, 8'h22, 2, 1, 8'h00, 0,   0,   0, 110,  2,   2,   0,  16,   2,   35,   1,   2,  8'h22, 8'h22, 8'h22);
`endif
        vecs[4] = mk(8'h33, 8'h44, 2, 1, 8'h00, 0,   2,   0, 110,  1,   1,   0,   8,   1,   35,   1,   0,  8'h33, 8'h33, 8'h33);
        vecs[5] = mk(8'h77, 8'h6B, 2, 1, 8'h00, 0,   0,   3, 110,  2,   1,   0,  11,   2,   13,   0,   0,  8'h6B, 8'h6B, 8'h6B);

        for (int unsigned i = 0; i < 6; i++) begin
            run_vec(vecs[i], i);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
